// File: rtl/booth_mul_ctrl.sv
// Radix-4 Booth multiplier: captures a/b on start and steps one digit per cycle.
// Product is registered on the final step and held until the next result.
module booth_mul_ctrl #(
  parameter  int N  = 8,
  localparam int SW = ($clog2(N/2) < 1) ? 1 : $clog2(N/2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [2:0]     sdn,
  output logic [SW-1:0]  step
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [N-1:0]    ar;
  logic [N-1:0]    br;
  logic [2*N-1:0]  acc;
  logic [SW-1:0]   cnt;
  logic            accept;
  logic            last;
  logic [N:0]      bx;
  logic [SW:0]     idx;
  logic [2:0]      trip;
  logic [2:0]      dsel;
  logic [2*N-1:0]  ax;
  logic [2*N-1:0]  mag;
  logic [2*N-1:0]  sh;
  logic [2*N-1:0]  addend;
  logic [2*N-1:0]  acc_nx;

  // b[-1] is the implicit zero below the LSB
  assign bx   = {br, 1'b0};
  assign idx  = {cnt, 1'b0};
  assign trip = bx[idx +: 3];
  assign last = (cnt == SW'(N/2 - 1));

  always_comb begin
    dsel = 3'b000;
    case (trip)
      3'b001, 3'b010: dsel = 3'b010;
      3'b011:         dsel = 3'b100;
      3'b100:         dsel = 3'b101;
      3'b101, 3'b110: dsel = 3'b011;
      default:        dsel = 3'b000;
    endcase
  end

  // negative digits: ones' complement here, +1 folded into the add
  assign ax     = {{N{ar[N-1]}}, ar};
  assign mag    = dsel[2] ? (ax << 1) : (dsel[1] ? ax : '0);
  assign sh     = mag << idx;
  assign addend = dsel[0] ? ~sh : sh;
  assign acc_nx = acc + addend + {{(2*N-1){1'b0}}, dsel[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar      <= '0;
      br      <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      ar  <= a;
      br  <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) product <= acc_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sdn  = busy ? dsel : 3'b000;
  assign step = busy ? cnt : '0;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Scoreboard bench for booth_mul_ctrl (N=8).
// Expected products come from an integer model; Booth digits from arithmetic.
module tb_booth_mul_ctrl;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2*N-1:0] product;
  logic [2:0]    sdn;
  logic [1:0]    step;

  int            npass = 0;
  int            ntot = 0;
  logic [15:0]   sbq[$];
  logic [15:0]   exp_prod = '0;
  bit            mon_en = 1'b0;

  booth_mul_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .sdn     (sdn),
    .step    (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      npass++;
  endtask

  function automatic logic [15:0] mul(input logic [7:0] x,
                                      input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  function automatic logic [2:0] mdig(input logic [7:0] y, input int i);
    logic [8:0] yx;
    int d;
    yx = {y, 1'b0};
    d = -2 * int'(yx[2*i+2]) + int'(yx[2*i+1]) + int'(yx[2*i]);
    case (d)
      1:       return 3'b010;
      2:       return 3'b100;
      -1:      return 3'b011;
      -2:      return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // done pops the scoreboard; otherwise product must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("extra_done", 32'(done), 32'd0);
        end else begin
          exp_prod = sbq.pop_front();
          chk("product", 32'(product), 32'(exp_prod));
        end
      end else begin
        chk("hold", 32'(product), 32'(exp_prod));
      end
    end
  end

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    if (!done) chk("timeout", 32'(done), 32'd1);
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    sbq.push_back(mul(x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("step", 32'(step), 32'(i));
      chk("sdn", 32'(sdn), 32'(mdig(y, i)));
      @(posedge clk);
    end
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("busy_d", 32'(busy), 32'd0);
    chk("sdn_d", 32'(sdn), 32'd0);
    chk("step_d", 32'(step), 32'd0);
    @(negedge clk);
    chk("done_off", 32'(done), 32'd0);
  endtask

  logic [7:0] bx[3];
  logic [7:0] by[3];
  int k;

  initial begin
    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    chk("rst_sdn", 32'(sdn), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    exp_prod = '0;
    mon_en = 1'b1;

    op(8'd7, 8'd3);
    op(8'h80, 8'h80);
    op(8'h80, 8'h7F);
    op(8'h55, 8'hAA);
    op(8'hFF, 8'hFF);
    for (int i = 0; i < 6; i++) op(8'($urandom), 8'($urandom));

    // start held: back-to-back results
    bx[0] = 8'hFF; by[0] = 8'hFF;
    bx[1] = 8'h13; by[1] = 8'hE7;
    bx[2] = 8'h80; by[2] = 8'h01;
    @(posedge clk); #1;
    start = 1'b1; a = bx[0]; b = by[0];
    sbq.push_back(mul(bx[0], by[0]));
    for (int j = 0; j < 3; j++) begin
      wait_done(k);
      chk(j == 0 ? "b2b_lat" : "b2b_period", 32'(k), j == 0 ? 32'd6 : 32'd5);
      if (j < 2) begin
        a = bx[j+1]; b = by[j+1];
        sbq.push_back(mul(bx[j+1], by[j+1]));
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    // start re-pulsed during RUN is ignored
    @(posedge clk); #1;
    start = 1'b1; a = 8'd7; b = 8'd3;
    sbq.push_back(mul(8'd7, 8'd3));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 8'd100; b = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(k);
    chk("ign_lat", 32'(k), 32'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_extra", 32'(done), 32'd0);
    end

    // reset mid-RUN at step 2
    @(posedge clk); #1;
    start = 1'b1; a = 8'd50; b = 8'd60;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_step", 32'(step), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_prod = '0;
    rst = 1'b0;
    start = 1'b1; a = 8'd5; b = 8'hFE;
    sbq.push_back(mul(8'd5, 8'hFE));
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_prod", 32'(product), 32'd0);
    chk("mr_sdn", 32'(sdn), 32'd0);
    chk("mr_step", 32'(step), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(k);
    chk("post_rst_lat", 32'(k), 32'd5);
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
